gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_arbiter_if.sv | 35 +++
 rtl/gcd_rr_arb.sv | 43 ++++
 rtl/gcd_arbiter.sv | 144 ++++++++++++++
 tb/tb_gcd_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the two-requester GCD arbiter: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gcd_pkg;

    localparam int GCD_W_DEF       = 16;
    localparam int GCD_TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Bundle of the requester-side job/response signals and the shared GCD datapath port.
// Latency: n/a (wiring only).
// Backpressure: req_ready is a one-hot accept pulse; rsp_valid is a one-hot result pulse with no stall.
// Ports: req_valid/a_in/b_in (requesters, packed [i*W +: W]), req_ready, rsp_valid/rsp_data/rsp_err,
//        gcd_start/gcd_a/gcd_b (to datapath), gcd_done/gcd_result (from datapath).
interface gcd_arbiter_if
    import gcd_pkg::*;
#(
    parameter int W = GCD_W_DEF
);
    logic [1:0]     req_valid;
    logic [2*W-1:0] a_in;
    logic [2*W-1:0] b_in;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           gcd_start;
    logic [W-1:0]   gcd_a;
    logic [W-1:0]   gcd_b;
    logic           gcd_done;
    logic [W-1:0]   gcd_result;

    // Arbiter side.
    modport slave (
        input  req_valid, a_in, b_in, gcd_done, gcd_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, gcd_start, gcd_a, gcd_b
    );

    // Requester/datapath side.
    modport master (
        output req_valid, a_in, b_in, gcd_done, gcd_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, gcd_start, gcd_a, gcd_b
    );
endinterface

// File: rtl/gcd_rr_arb.sv
// Two-way round-robin grant: combinational pick, registered last-served pointer.
// Latency: grant is same-cycle from req; pointer update lands on the next clk edge.
// Backpressure: none; the caller decides when a grant is consumed and reports it via upd_vld.
// Ports: clk, rst (sync, active-high), req[1:0], upd_vld/upd_idx (served requester), grant (one-hot), grant_idx.
module gcd_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd_vld,
    input  logic       upd_idx,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic last_q;
    logic last_d;

    always_comb begin
        grant_idx = 1'b0;
        grant     = 2'b00;
        last_d    = last_q;
        // On a tie the requester not served last wins; otherwise the lone requester wins.
        if (req == 2'b11) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req[1];
        end
        if (req != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
        if (upd_vld) begin
            last_d = upd_idx;
        end
    end

    // Pointer starts at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD datapath between two requesters with round-robin arbitration; zero operands bypass the datapath.
// Latency: req_ready -> rsp_valid is datapath cycles + 3, or 1 cycle when an operand is zero.
// Backpressure: jobs are accepted only in IDLE (one in flight); responses are single-cycle pulses, never stalled.
// Ports: clk, rst (sync, active-high), bus (gcd_arbiter_if.slave).
// Build option: define GCD_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles with rsp_err=1, rsp_data=0.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W_DEF,
    parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    gcd_arbiter_if.slave bus
);
    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic [W-1:0] gcd_a_q, gcd_a_d;
    logic [W-1:0] gcd_b_q, gcd_b_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]   grant;
    logic         grant_idx;
    logic [W-1:0] a_sel, b_sel;
    logic         upd_vld;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    gcd_rr_arb u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .upd_vld   (upd_vld),
        .upd_idx   (gnt_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign a_sel = grant_idx ? bus.a_in[2*W-1:W] : bus.a_in[W-1:0];
    assign b_sel = grant_idx ? bus.b_in[2*W-1:W] : bus.b_in[W-1:0];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gcd_a_d    = gcd_a_q;
        gcd_b_d    = gcd_b_q;
        rsp_data_d = rsp_data_q;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    gnt_d   = grant_idx;
                    gcd_a_d = a_sel;
                    gcd_b_d = b_sel;
`ifdef GCD_ARB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    if (a_sel == '0 || b_sel == '0) begin
                        // gcd(x,0) = x: with one side zero the OR is the other side (0 for gcd(0,0)).
                        rsp_data_d = a_sel | b_sel;
                        state_d    = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    rsp_data_d = bus.gcd_result;
                    state_d    = RESP;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                // Counter reads 0..TIMEOUT-1 across the WAIT cycles; abort on the last one.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            gcd_a_q    <= '0;
            gcd_b_q    <= '0;
            rsp_data_q <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gcd_a_q    <= gcd_a_d;
            gcd_b_q    <= gcd_b_d;
            rsp_data_q <= rsp_data_d;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    // Strobes decode from the state register; rst masks them so nothing leaks during reset.
    assign bus.req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign bus.gcd_start = (state_q == ISSUE) && !rst;
    assign bus.rsp_valid = (state_q == RESP && !rst) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign upd_vld       = (state_q == RESP) && !rst;
    assign bus.gcd_a     = gcd_a_q;
    assign bus.gcd_b     = gcd_b_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef GCD_ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed + randomized bench for gcd_arbiter with an arithmetic reference model and a datapath stand-in.
// Latency: n/a.
// Backpressure: n/a.
module tb_gcd_arbiter;
    localparam int W  = 16;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_arbiter_if #(.W(W)) bus ();

    gcd_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_served = 1;
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.gcd_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return 1 - last_served;
        return r[1] ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 4) == 0) return '0;
        return W'($urandom_range(1, 90) * $urandom_range(1, 12));
    endfunction

    task automatic set_ops(input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
        av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1;
        bus.a_in = {a1, a0};
        bus.b_in = {b1, b0};
    endtask

    // Entry/exit: 1 time unit after a rising edge, in a cycle where the DUT is idle.
    // dly >= 0: datapath raises gcd_done dly+1 cycles after the gcd_start cycle; dly < 0: never.
    task automatic do_job(input logic [1:0] req, input logic [1:0] keep, input int dly, input bit stray);
        int g, n, t_rdy, lat, start0;
        logic [W-1:0] want_d;
        logic want_e;
        bit byp;
        g      = pick(req);
        byp    = (av[g] == 0) || (bv[g] == 0);
        want_d = gcd_ref(av[g], bv[g]);
        want_e = 1'b0;
        lat    = byp ? 1 : dly + 3;
        if (dly < 0 && !byp) begin
            want_d = '0;
            want_e = 1'b1;
            lat    = TO + 2;
        end
        start0 = start_cnt;
        bus.gcd_done  = 1'b0;
        bus.req_valid = req;
        #3;
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            clk_step(); #3; n++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(1 << g));
        t_rdy = cyc;
        clk_step();
        bus.req_valid = keep;
        bus.a_in = 32'($urandom);
        bus.b_in = 32'($urandom);
        if (!byp) begin
            if (stray) begin
                bus.gcd_done   = 1'b1;
                bus.gcd_result = ~want_d;
            end
            #3;
            chk("gcd_start", 32'(bus.gcd_start), 32'd1);
            chk("gcd_a", 32'(bus.gcd_a), 32'(av[g]));
            chk("gcd_b", 32'(bus.gcd_b), 32'(bv[g]));
            chk("no_accept_issue", 32'(bus.req_ready), 32'd0);
            if (dly >= 0) begin
                for (int i = 0; i < dly; i++) begin
                    clk_step();
                    bus.gcd_done = 1'b0;
                    #3;
                    chk("wait_stable_a", 32'(bus.gcd_a), 32'(av[g]));
                    chk("wait_stable_b", 32'(bus.gcd_b), 32'(bv[g]));
                    chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
                    chk("no_accept_wait", 32'(bus.req_ready), 32'd0);
                    chk("single_start", 32'(bus.gcd_start), 32'd0);
                end
                clk_step();
                bus.gcd_done   = 1'b1;
                bus.gcd_result = want_d;
                #3;
                chk("done_stable_a", 32'(bus.gcd_a), 32'(av[g]));
                clk_step();
                bus.gcd_done   = stray;
                bus.gcd_result = ~want_d;
            end else begin
                clk_step();
                bus.gcd_done = 1'b0;
            end
        end
        #3;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < TO + 20) begin
            clk_step(); #3; n++;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << g));
        chk("rsp_data", 32'(bus.rsp_data), 32'(want_d));
        chk("rsp_err", 32'(bus.rsp_err), 32'(want_e));
        chk("latency", 32'(cyc - t_rdy), 32'(lat));
        chk("start_count", 32'(start_cnt - start0), byp ? 32'd0 : 32'd1);
        last_served = g;
        clk_step();
        bus.gcd_done = 1'b0;
        bus.a_in = {av[1], av[0]};
        bus.b_in = {bv[1], bv[0]};
    endtask

    task automatic do_reset();
        bus.req_valid = 2'b00;
        bus.gcd_done  = 1'b0;
        rst = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;
        last_served = 1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.gcd_done   = 1'b0;
        bus.gcd_result = '0;

        // Reset state; a request during reset must not be accepted.
        clk_step();
        clk_step();
        bus.req_valid = 2'b11;
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        clk_step();
        bus.req_valid = 2'b00;
        rst = 1'b0;
        #3;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_gcd_start", 32'(bus.gcd_start), 32'd0);
        chk("rst_gcd_a", 32'(bus.gcd_a), 32'd0);
        chk("rst_gcd_b", 32'(bus.gcd_b), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        clk_step();

        // gcd(48,18) with a 5-cycle datapath.
        set_ops(16'd48, 16'd18, 16'd0, 16'd0);
        do_job(2'b01, 2'b00, 5, 1'b0);

        // Both requesters held from reset: 0 first, then 1.
        do_reset();
        set_ops(16'd84, 16'd36, 16'd91, 16'd39);
        do_job(2'b11, 2'b11, 2, 1'b0);
        do_job(2'b11, 2'b00, 3, 1'b0);

        // Zero-operand bypass.
        set_ops(16'd0, 16'd35, 16'd0, 16'd0);
        do_job(2'b01, 2'b00, 3, 1'b0);
        set_ops(16'd0, 16'd0, 16'd0, 16'd0);
        do_job(2'b10, 2'b00, 3, 1'b0);

        // Reset in the middle of WAIT, then a stray gcd_done.
        set_ops(16'd40, 16'd24, 16'd0, 16'd0);
        bus.req_valid = 2'b01;
        #3;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        clk_step();
        bus.req_valid = 2'b00;
        clk_step();
        clk_step();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        last_served = 1;
        bus.gcd_done   = 1'b1;
        bus.gcd_result = 16'd8;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("abort_no_start", 32'(bus.gcd_start), 32'd0);
            chk("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
            clk_step();
            bus.gcd_done = 1'b0;
        end
        set_ops(16'd40, 16'd24, 16'd27, 16'd45);
        do_job(2'b11, 2'b00, 1, 1'b0);

`ifdef GCD_ARB_TIMEOUT_EN
        // Datapath never answers: abort after TO WAIT cycles.
        set_ops(16'd100, 16'd75, 16'd0, 16'd0);
        do_job(2'b01, 2'b00, -1, 1'b0);
        do_job(2'b01, 2'b00, 2, 1'b0);
`endif

        // Randomized jobs: random requesters, operands, datapath delay, held requests, stray done pulses.
        for (int j = 0; j < 24; j++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            set_ops(rnd_op(), rnd_op(), rnd_op(), rnd_op());
            do_job(rq, ($urandom_range(0, 1) == 1) ? rq : 2'b00,
                   int'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
